piano_keyboard_renderer: RTL and testbench

Parametrised, pipelined pixel generator for the projected keyboard. It draws NUM_WHITE white keys with interleaved black keys in the standard C-D-E-F-G-A-B octave pattern. Keys that are pressed are highlighted, and the highlight is held for a programmable number of frames after release. It sits in the video path between the XVGA timing generator and the pixel mux, replacing per-key sprite instances with one block driven by key-press vectors.

---
 rtl/piano_keyboard_renderer_if.sv | 24 ++
 rtl/piano_keyboard_renderer.sv | 193 +++++++++++++++++++
 tb/tb_piano_keyboard_renderer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/piano_keyboard_renderer_if.sv
// Video-path bundle for the keyboard renderer: timing, geometry and press inputs
// in, registered RGB pixel out.
interface piano_keyboard_renderer_if #(
  parameter int unsigned NUM_WHITE = 14
);
  logic                 frame_start;
  logic [10:0]          x;
  logic [9:0]           y;
  logic [10:0]          hcount;
  logic [9:0]           vcount;
  logic [NUM_WHITE-1:0] white_pressed;
  logic [NUM_WHITE-1:0] black_pressed;
  logic [23:0]          pixel;

  modport master (
    output frame_start, x, y, hcount, vcount, white_pressed, black_pressed,
    input  pixel
  );

  modport slave (
    input  frame_start, x, y, hcount, vcount, white_pressed, black_pressed,
    output pixel
  );
endinterface

// File: rtl/piano_keyboard_renderer.sv
// Two-stage pixel generator for a projected piano keyboard with per-key
// press highlighting held for a programmable number of frames.
module piano_keyboard_renderer #(
  parameter int unsigned NUM_WHITE        = 14,
  parameter int unsigned WHITE_KEY_WIDTH  = 64,
  parameter int unsigned HEIGHT           = 300,
  parameter int unsigned BLACK_KEY_WIDTH  = 32,
  parameter int unsigned BLACK_KEY_HEIGHT = 180,
  parameter int unsigned HOLD_FRAMES      = 3,
  parameter logic [23:0] WHITE_COLOR      = 24'hFF_FF_FF,
  parameter logic [23:0] BLACK_COLOR      = 24'h00_00_00,
  parameter logic [23:0] PRESS_COLOR      = 24'hFF_00_00,
  parameter logic [23:0] GAP_COLOR        = 24'h80_80_80
) (
  input logic                       vclock,
  input logic                       reset,
  piano_keyboard_renderer_if.slave  vid
);

  localparam int unsigned OW = (WHITE_KEY_WIDTH > 2) ? $clog2(WHITE_KEY_WIDTH) : 1;
  localparam logic [OW-1:0] OFF_LAST    = OW'(WHITE_KEY_WIDTH - 1);
  localparam logic [OW-1:0] BLACK_RIGHT = OW'(WHITE_KEY_WIDTH - BLACK_KEY_WIDTH / 2);
  localparam logic [OW-1:0] BLACK_LEFT  = OW'(BLACK_KEY_WIDTH / 2);
  localparam logic [11:0]   SPAN        = 12'(NUM_WHITE * WHITE_KEY_WIDTH);
  localparam logic [3:0]    HOLD        = 4'(HOLD_FRAMES);

  // Bit i set when a black key sits right of white key i (C D _ F G A _ pattern).
  function automatic logic [31:0] black_map();
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) begin
      if ((i < int'(NUM_WHITE) - 1) && ((i % 7) inside {0, 1, 3, 4, 5})) begin
        m[i] = 1'b1;
      end
    end
    return m;
  endfunction

  localparam logic [31:0] BLACK_EXISTS = black_map();

  function automatic logic [3:0] next_count(logic [3:0] cnt, logic pressed);
    if (pressed) begin
      return HOLD;
    end else if (cnt != 4'd0) begin
      return cnt - 4'd1;
    end
    return cnt;
  endfunction

  typedef enum logic [1:0] {SelNone, SelGap, SelKey} sel_e;

  // Frame latch and hold counters
  logic [10:0] x_lat_q;
  logic [9:0]  y_lat_q;
  logic [3:0]  white_cnt_q [NUM_WHITE];
  logic [3:0]  black_cnt_q [NUM_WHITE];

  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      x_lat_q <= '0;
      y_lat_q <= '0;
      for (int i = 0; i < int'(NUM_WHITE); i++) begin
        white_cnt_q[i] <= '0;
        black_cnt_q[i] <= '0;
      end
    end else if (vid.frame_start) begin
      x_lat_q <= vid.x;
      y_lat_q <= vid.y;
      for (int i = 0; i < int'(NUM_WHITE); i++) begin
        white_cnt_q[i] <= next_count(white_cnt_q[i], vid.white_pressed[i]);
        black_cnt_q[i] <= BLACK_EXISTS[i] ? next_count(black_cnt_q[i], vid.black_pressed[i])
                                          : 4'd0;
      end
    end
  end

  logic [31:0] white_hl;
  logic [31:0] black_hl;

  always_comb begin
    white_hl = '0;
    black_hl = '0;
    for (int i = 0; i < int'(NUM_WHITE); i++) begin
      white_hl[i] = |white_cnt_q[i];
      black_hl[i] = |black_cnt_q[i];
    end
  end

  // Span and row qualification
  logic [11:0] span_lo;
  logic [11:0] span_hi;
  logic [10:0] row_lo;
  logic        in_span;
  logic        white_row;
  logic        black_row;

  assign span_lo   = {1'b0, x_lat_q};
  assign span_hi   = span_lo + SPAN;
  assign in_span   = ({1'b0, vid.hcount} >= span_lo) && ({1'b0, vid.hcount} < span_hi);
  assign row_lo    = {1'b0, y_lat_q};
  assign white_row = ({1'b0, vid.vcount} >= row_lo) &&
                     ({1'b0, vid.vcount} < row_lo + 11'(HEIGHT));
  assign black_row = ({1'b0, vid.vcount} >= row_lo) &&
                     ({1'b0, vid.vcount} < row_lo + 11'(BLACK_KEY_HEIGHT));

  // Incremental column tracker: replaces a divide by WHITE_KEY_WIDTH.
  logic [4:0]    idx_q, idx_d, idx_m1;
  logic [OW-1:0] off_q, off_d;

  always_comb begin
    idx_d = idx_q;
    off_d = off_q;
    if (vid.hcount == x_lat_q) begin
      idx_d = '0;
      off_d = '0;
    end else if (in_span) begin
      if (off_q == OFF_LAST) begin
        off_d = '0;
        idx_d = idx_q + 5'd1;
      end else begin
        off_d = off_q + OW'(1);
      end
    end
  end

  assign idx_m1 = idx_d - 5'd1;

  sel_e sel_d, sel_q;
  logic hl_d, hl_q;
  logic black_d, black_q;

  always_comb begin
    sel_d   = SelNone;
    hl_d    = 1'b0;
    black_d = 1'b0;
    if (in_span && white_row) begin
      if (black_row && (off_d >= BLACK_RIGHT) && BLACK_EXISTS[idx_d]) begin
        sel_d   = SelKey;
        black_d = 1'b1;
        hl_d    = black_hl[idx_d];
      end else if (black_row && (off_d < BLACK_LEFT) && (idx_d != '0) &&
                   BLACK_EXISTS[idx_m1]) begin
        sel_d   = SelKey;
        black_d = 1'b1;
        hl_d    = black_hl[idx_m1];
      end else if (off_d == '0) begin
        sel_d = SelGap;
      end else begin
        sel_d = SelKey;
        hl_d  = white_hl[idx_d];
      end
    end
  end

  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      idx_q   <= '0;
      off_q   <= '0;
      sel_q   <= SelNone;
      hl_q    <= 1'b0;
      black_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      off_q   <= off_d;
      sel_q   <= sel_d;
      hl_q    <= hl_d;
      black_q <= black_d;
    end
  end

  // Stage 2: colour
  logic [23:0] pixel_d, pixel_q;

  always_comb begin
    pixel_d = '0;
    unique case (sel_q)
      SelGap:  pixel_d = GAP_COLOR;
      SelKey:  pixel_d = hl_q ? PRESS_COLOR : (black_q ? BLACK_COLOR : WHITE_COLOR);
      default: pixel_d = '0;
    endcase
  end

  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      pixel_q <= '0;
    end else begin
      pixel_q <= pixel_d;
    end
  end

  assign vid.pixel = pixel_q;

endmodule

// File: tb/tb_piano_keyboard_renderer.sv
// Bench for piano_keyboard_renderer: arithmetic reference model checked every
// swept pixel, plus hand-computed literal probes.
module tb_piano_keyboard_renderer;
  localparam int NW   = 14;
  localparam int WKW  = 64;
  localparam int H    = 300;
  localparam int BKW  = 32;
  localparam int BKH  = 180;
  localparam int HOLD = 3;

  logic vclock = 1'b0;
  logic reset  = 1'b1;
  bit   chk    = 1'b0;

  int n_pass  = 0;
  int n_total = 0;
  int n_print = 0;

  piano_keyboard_renderer_if #(.NUM_WHITE(NW)) vid ();

  piano_keyboard_renderer #(.NUM_WHITE(NW)) dut (
    .vclock (vclock),
    .reset  (reset),
    .vid    (vid)
  );

  always #5 vclock = ~vclock;

  // Reference model state
  int          mx, my;
  int          mwc [NW];
  int          mbc [NW];
  logic [23:0] p1, p2;
  bit          v1, v2;
  int          h1, h2, y1, y2;

  function automatic bit bex(int i);
    int m;
    m = i % 7;
    return (m == 0 || m == 1 || m == 3 || m == 4 || m == 5) && (i < NW - 1);
  endfunction

  function automatic logic [23:0] key_col(int cnt, bit blk);
    if (cnt != 0) return 24'hFF0000;
    return blk ? 24'h000000 : 24'hFFFFFF;
  endfunction

  function automatic logic [23:0] model_pix(int h, int v);
    int i, o;
    bit brow;
    if (h < mx || h >= mx + NW * WKW || v < my || v >= my + H) return 24'h0;
    i    = (h - mx) / WKW;
    o    = (h - mx) % WKW;
    brow = v < my + BKH;
    if (brow && o >= WKW - BKW / 2 && bex(i)) return key_col(mbc[i], 1'b1);
    if (brow && o < BKW / 2 && i > 0 && bex(i - 1)) return key_col(mbc[i - 1], 1'b1);
    if (o == 0) return 24'h808080;
    return key_col(mwc[i], 1'b0);
  endfunction

  always @(posedge vclock or posedge reset) begin
    if (reset) begin
      mx <= 0;
      my <= 0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      for (int i = 0; i < NW; i++) begin
        mwc[i] <= 0;
        mbc[i] <= 0;
      end
    end else begin
      p1 <= model_pix(int'(vid.hcount), int'(vid.vcount));
      v1 <= chk;
      h1 <= int'(vid.hcount);
      y1 <= int'(vid.vcount);
      p2 <= p1;
      v2 <= v1;
      h2 <= h1;
      y2 <= y1;
      if (vid.frame_start) begin
        mx <= int'(vid.x);
        my <= int'(vid.y);
        for (int i = 0; i < NW; i++) begin
          mwc[i] <= vid.white_pressed[i] ? HOLD : (mwc[i] > 0 ? mwc[i] - 1 : 0);
          mbc[i] <= (bex(i) && vid.black_pressed[i]) ? HOLD : (mbc[i] > 0 ? mbc[i] - 1 : 0);
        end
      end
    end
  end

  always @(negedge vclock) begin
    if (!reset && v2) begin
      n_total++;
      if (vid.pixel === p2) begin
        n_pass++;
      end else if (n_print < 20) begin
        n_print++;
        $display("FAIL stream h=%0d v=%0d got %h want %h", h2, y2, vid.pixel, p2);
      end
    end
  end

  task automatic check(string name, logic [23:0] got, logic [23:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s got %h want %h", name, got, want);
  endtask

  task automatic frame(logic [NW-1:0] wp, logic [NW-1:0] bp, int xx, int yy);
    @(posedge vclock); #1;
    vid.x = 11'(xx);
    vid.y = 10'(yy);
    vid.white_pressed = wp;
    vid.black_pressed = bp;
    vid.frame_start = 1'b1;
    vid.hcount = '0;
    vid.vcount = '0;
    chk = 1'b0;
    @(posedge vclock); #1;
    vid.frame_start = 1'b0;
    // Presses between pulses must not matter
    vid.white_pressed = NW'($urandom);
    vid.black_pressed = NW'($urandom);
  endtask

  task automatic sweep(int v, int hmax);
    for (int hh = 0; hh <= hmax; hh++) begin
      @(posedge vclock); #1;
      vid.hcount = 11'(hh);
      vid.vcount = 10'(v);
      chk = 1'b1;
    end
    @(posedge vclock); #1;
    vid.hcount = '0;
    chk = 1'b0;
  endtask

  task automatic lit(string name, int h, int v, logic [23:0] want);
    sweep(v, h);
    @(posedge vclock); #1;
    check(name, vid.pixel, want);
  endtask

  initial begin
    vid.frame_start   = 1'b0;
    vid.x             = '0;
    vid.y             = '0;
    vid.hcount        = '0;
    vid.vcount        = '0;
    vid.white_pressed = '0;
    vid.black_pressed = '0;
    reset = 1'b1;
    repeat (3) @(posedge vclock);
    #1;
    check("reset_pixel", vid.pixel, 24'h0);
    reset = 1'b0;
    @(posedge vclock); #1;
    check("fill_after_release", vid.pixel, 24'h0);

    // Idle pattern
    frame('0, '0, 100, 200);
    lit("idle_gap_100", 100, 250, 24'h808080);
    lit("idle_white_101", 101, 250, 24'hFFFFFF);
    lit("idle_black_150", 150, 250, 24'h000000);
    lit("idle_e_278", 278, 250, 24'hFFFFFF);
    lit("idle_black_174", 174, 250, 24'h000000);
    lit("idle_white_302", 302, 250, 24'hFFFFFF);
    lit("idle_lowrow_150", 150, 400, 24'hFFFFFF);
    lit("span_last_995", 995, 400, 24'hFFFFFF);
    lit("span_past_996", 996, 400, 24'h000000);
    lit("span_before_99", 99, 400, 24'h000000);
    lit("row_past_500", 150, 500, 24'h000000);
    lit("row_last_499", 150, 499, 24'hFFFFFF);
    sweep(250, 1100);
    sweep(400, 1100);

    // Press and hold of white key 1
    frame(NW'(1) << 1, '0, 100, 200);
    lit("hold_n_white", 180, 400, 24'hFF0000);
    lit("hold_n_black_top", 174, 250, 24'h000000);
    sweep(400, 1100);
    frame('0, '0, 100, 200);
    lit("hold_n1_white", 180, 400, 24'hFF0000);
    lit("hold_n1_black_top", 174, 250, 24'h000000);
    frame('0, '0, 100, 200);
    lit("hold_n2_white", 180, 400, 24'hFF0000);
    lit("hold_n2_black_top", 174, 250, 24'h000000);
    frame('0, '0, 100, 200);
    lit("hold_n3_released", 180, 400, 24'hFFFFFF);

    // Black presses, including positions with no black key
    frame('0, NW'(1), 100, 200);
    lit("black0_pressed", 150, 250, 24'hFF0000);
    frame('0, (NW'(1) << 6) | (NW'(1) << 13), 100, 200);
    lit("black0_held", 150, 250, 24'hFF0000);
    lit("no_black_6", 534, 250, 24'hFFFFFF);
    lit("no_black_13", 982, 250, 24'hFFFFFF);
    sweep(250, 1100);

    // Geometry latched only at frame_start
    frame('0, '0, 100, 200);
    vid.x = 11'd200;
    lit("geom_old_gap", 100, 250, 24'h808080);
    lit("geom_old_200", 200, 250, 24'hFFFFFF);
    sweep(250, 1100);
    frame('0, '0, 200, 200);
    lit("geom_new_gap", 200, 250, 24'h808080);
    lit("geom_new_left", 100, 250, 24'h000000);
    sweep(250, 1300);

    // Asynchronous reset with a key highlighted
    frame(NW'(1) << 1, '0, 100, 200);
    lit("pre_reset_hl", 180, 400, 24'hFF0000);
    #2;
    reset = 1'b1;
    #1;
    check("reset_async", vid.pixel, 24'h0);
    repeat (2) @(posedge vclock);
    #1;
    reset = 1'b0;
    @(posedge vclock); #1;
    check("reset_fill", vid.pixel, 24'h0);
    frame('0, '0, 100, 200);
    lit("post_reset_no_hl", 180, 400, 24'hFFFFFF);
    lit("post_reset_gap", 100, 250, 24'h808080);
    sweep(250, 1100);
    sweep(400, 1100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
